conv_mac_accum_16bit: RTL
=========================

// Module: conv_mac_accum_16bit
// PURPOSE
//  Signed Q8.8 multiply-accumulate stage downstream of the 16-bit operand mux in the conv datapath.
//  Consumes one (pixel, weight) pair per accepted beat; pixel is the mux output (feature or zero-pad).
//  Sums KERNEL_LEN products into a wide accumulator, then emits one rounded-down, saturated 16-bit result.
//  Two-stage pipeline (multiply reg, accumulate reg); valid/ready on both sides.
// PARAMETERS
//  KERNEL_LEN  9   products per output window; legal 1..256
//  FRAC_BITS   8   fractional bits of operands and result (Q8.8)
//  ACC_W       40  accumulator width; must be >= 32+ceil(log2(KERNEL_LEN))
// PORTS
//  clk        in   1   single clock; all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   pixel/weight pair valid
//  in_ready   out  1   block can accept a pair this cycle
//  pixel      in   16  signed Q8.8 operand from 2:1 mux
//  weight     in   16  signed Q8.8 kernel weight
//  out_valid  out  1   out_data holds a finished window result
//  out_ready  in   1   downstream accepts out_data
//  out_data   out  16  signed Q8.8 saturated window sum
//  busy       out  1   a window is in progress (count!=0 or pipeline/flush/output active)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=S_ACC, acc=0, prod_reg=0, prod_vld=0, cnt=0, out_data=0, out_valid=0.
//   in_ready = (state==S_ACC) & ~rst, so in_ready=0 while rst high; busy=0 after reset.
//   Reset mid-window discards partial sum and any pending output; no partial result ever emitted.
//  Accept: beat taken when in_valid & in_ready at a rising edge. No accept in any other state; in_valid ignored there.
//  Stage 1: on accept, prod_reg <= $signed(pixel)*$signed(weight) (32b), prod_vld<=1; else prod_vld<=0.
//  Stage 2: if prod_vld, acc <= acc + sign_ext(prod_reg, ACC_W).
//  FSM:
//   S_ACC:   accept beats; cnt++ per accept. On accept with cnt==KERNEL_LEN-1 -> S_FLUSH, cnt<=0.
//   S_FLUSH: in_ready=0; last product added to acc this edge -> S_OUT.
//   S_OUT:   out_data <= sat16(acc >>> FRAC_BITS), out_valid<=1 -> S_HOLD.
//   S_HOLD:  out_valid=1, out_data stable. On out_ready: out_valid<=0, acc<=0 -> S_ACC.
//  Latency: last beat accepted at edge N -> out_valid high after edge N+3 (3 cycles). With out_ready=1,
//   out_valid is high exactly 1 cycle; in_ready high the following cycle. Min window period KERNEL_LEN+4 cycles.
//  Arithmetic: full-precision signed sum, arithmetic shift right FRAC_BITS (floor, no rounding),
//   then saturate: >32767 -> 16'h7FFF, < -32768 -> 16'h8000. acc never wraps for legal KERNEL_LEN.
//  KERNEL_LEN==1: first accept goes straight to S_FLUSH.
//  Bubbles: in_valid gaps in S_ACC only stall cnt; result identical to back-to-back feed.
//  out_ready asserted while out_valid=0 has no effect.
// TESTING
//  1. KERNEL_LEN=9, 9 beats pixel=16'h0100 weight=16'h0100 back-to-back -> out_data=16'h0900, out_valid 3 cycles after 9th accept.
//  2. Saturation: 9 x (16'h7FFF*16'h7FFF) -> 16'h7FFF; 9 x (16'h8000*16'h7FFF) -> 16'h8000.
//  3. Floor: 9 x (16'h0001*16'h0001) -> 16'h0000; 9 x (16'hFFFF*16'h0001) -> 16'hFFFF.
//  4. Backpressure: out_ready=0 for 5 cycles -> out_data stable, in_ready=0, offered beats not taken; release -> next window starts from acc=0.
//  5. Random in_valid gaps (~50%) on test-1 data -> 16'h0900; beat count at accept equals exactly 9.
//  6. rst pulsed 1 cycle after 4 accepted beats, then test-1 data -> 16'h0900 (no carry-over), busy=0 right after reset.

Source files
------------

// File: rtl/conv_mac_accum_16bit_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac_accum_16bit_if
// Brief    : Operand-in / result-out handshake bundle for the Q8.8 MAC stage.
// Revision : 1.0
// ============================================================================
interface conv_mac_accum_16bit_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] pixel;
    logic signed [15:0] weight;
    logic               out_valid;
    logic               out_ready;
    logic        [15:0] out_data;
    logic               busy;

    modport master (
        output in_valid,
        output pixel,
        output weight,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  pixel,
        input  weight,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/conv_mac_accum_16bit.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac_accum_16bit
// Brief    : Signed Q8.8 multiply-accumulate over KERNEL_LEN beats, emitting
//            one floored, saturated 16-bit window result.
// Revision : 1.0
// ============================================================================
module conv_mac_accum_16bit #(
    parameter int KERNEL_LEN = 9,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_W      = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    conv_mac_accum_16bit_if.slave  mac_if
);

    localparam int CNT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
    localparam int SH_W  = ACC_W - FRAC_BITS;

    localparam logic [CNT_W-1:0]        C_CNT_LAST = CNT_W'(KERNEL_LEN - 1);
    localparam logic signed [SH_W-1:0]  C_POS_LIM  = SH_W'(32767);
    localparam logic signed [SH_W-1:0]  C_NEG_LIM  = SH_W'(-32768);

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_FLUSH = 2'd1,
        S_OUT   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [31:0]         prod_q, prod_d;
    logic                       prod_vld_q, prod_vld_d;
    logic [15:0]                out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;

    logic                       w_in_ready;
    logic                       w_accept;
    logic signed [31:0]         w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [SH_W-1:0]     w_shifted;
    logic [15:0]                w_sat;

    assign w_in_ready = (state_q == S_ACC) & ~rst;
    assign w_accept   = mac_if.in_valid & w_in_ready;

    // Operands are sign-extended first so the 32-bit product keeps full precision.
    assign w_prod = $signed({{16{mac_if.pixel[15]}}, mac_if.pixel})
                  * $signed({{16{mac_if.weight[15]}}, mac_if.weight});

    assign w_prod_ext = {{(ACC_W-32){prod_q[31]}}, prod_q};

    // Dropping the low FRAC_BITS of a two's-complement value is a floor shift.
    assign w_shifted = acc_q[ACC_W-1:FRAC_BITS];

    always_comb begin
        w_sat = w_shifted[15:0];
        if (w_shifted > C_POS_LIM) begin
            w_sat = 16'h7FFF;
        end else if (w_shifted < C_NEG_LIM) begin
            w_sat = 16'h8000;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_vld_d  = w_accept;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (w_accept) begin
            prod_d = w_prod;
        end

        if (prod_vld_q) begin
            acc_d = acc_q + w_prod_ext;
        end

        case (state_q)
            S_ACC: begin
                if (w_accept) begin
                    if (cnt_q == C_CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_FLUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            // Stay until the product register has drained into the accumulator.
            S_FLUSH: begin
                if (!prod_vld_q) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_data_d  = w_sat;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (mac_if.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    state_d     = S_ACC;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign mac_if.in_ready  = w_in_ready;
    assign mac_if.out_valid = out_valid_q;
    assign mac_if.out_data  = out_data_q;
    assign mac_if.busy      = (cnt_q != '0) | prod_vld_q | (state_q != S_ACC) | out_valid_q;

endmodule
`default_nettype wire
